// File: rtl/risc_pipe_core.sv
// risc_pipe_core: single-clock five-stage pipeline (IF/ID/EX/MEM/WB) with
// EX forwarding, load-use interlock, branch flush and retire/cycle/stall counters.
module risc_pipe_core #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        halted,
    output logic [31:0] instret,
    output logic [31:0] cycles,
    output logic [31:0] stalls
);
    // Memory words must hold a full 32-bit instruction even when XLEN is narrower.
    localparam int MW = (XLEN > 32) ? XLEN : 32;
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB   = 6'b000001, OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011, OP_SLT   = 6'b000100, OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000, OP_SW    = 6'b001001, OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI  = 6'b001100, OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT   = 6'b111111;

    typedef struct packed {
        logic       use_rs;
        logic       use_rt;
        logic       we;      // writes a real register (never R0, never >= NREG)
        logic       lw;
        logic       sw;
        logic       hlt;
        logic [4:0] dst;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t       d;
        logic [5:0] op;
        logic       r_type, i_type, br;
        op       = ir[31:26];
        r_type   = (op <= OP_MUL);
        i_type   = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI);
        br       = (op == OP_BNEQZ) || (op == OP_BEQZ);
        d.lw     = (op == OP_LW);
        d.sw     = (op == OP_SW);
        d.hlt    = (op == OP_HLT);
        d.use_rs = r_type || i_type || d.lw || d.sw || br;
        d.use_rt = r_type || d.sw;
        d.dst    = r_type ? ir[15:11] : ir[20:16];
        d.we     = (r_type || i_type || d.lw) && (d.dst != 5'd0) && (int'(d.dst) < NREG);
        return d;
    endfunction

    logic [MW-1:0]   Mem [MEM_DEPTH];
    logic [XLEN-1:0] Reg [NREG];

    // Pipeline state
    logic [AW-1:0]   pc_q;
    logic            fetch_stop_q;
    logic            ifid_v_q;
    logic [31:0]     ifid_ir_q;
    logic [AW-1:0]   ifid_pc_q;
    logic            idex_v_q, idex_we_q, idex_lw_q, idex_sw_q, idex_hlt_q;
    logic [4:0]      idex_dst_q;
    logic [31:0]     idex_ir_q;
    logic [AW-1:0]   idex_pc_q;
    logic [XLEN-1:0] idex_a_q, idex_b_q;
    logic            exmem_v_q, exmem_we_q, exmem_lw_q, exmem_sw_q, exmem_hlt_q;
    logic [4:0]      exmem_dst_q;
    logic [XLEN-1:0] exmem_res_q, exmem_sd_q;
    logic            memwb_v_q, memwb_we_q, memwb_hlt_q;
    logic [4:0]      memwb_dst_q;
    logic [XLEN-1:0] memwb_val_q;
    logic            halted_q;
    logic [31:0]     instret_q, cycles_q, stalls_q;

    // ID / EX combinational signals
    dec_t            id_dec;
    logic [4:0]      id_rs, id_rt, ex_rs, ex_rt;
    logic [5:0]      ex_op;
    logic [XLEN-1:0] id_a, id_b, ex_a, ex_b, ex_imm, ex_res;
    logic [AW-1:0]   ex_target;
    logic            wb_we, ex_taken, load_use, stop_fetch;

    assign id_dec    = decode(ifid_ir_q);
    assign id_rs     = ifid_ir_q[25:21];
    assign id_rt     = ifid_ir_q[20:16];
    assign ex_op     = idex_ir_q[31:26];
    assign ex_rs     = idex_ir_q[25:21];
    assign ex_rt     = idex_ir_q[20:16];
    assign ex_imm    = XLEN'($signed(idex_ir_q[15:0]));
    assign wb_we     = memwb_v_q && memwb_we_q && !halted_q;
    assign ex_taken  = idex_v_q && (((ex_op == OP_BNEQZ) && (ex_a != '0)) ||
                                    ((ex_op == OP_BEQZ)  && (ex_a == '0)));
    assign ex_target = idex_pc_q + AW'(1) + ex_imm[AW-1:0];
    assign load_use  = ifid_v_q && idex_v_q && idex_lw_q &&
                       ((id_dec.use_rs && (id_rs == ex_rt)) || (id_dec.use_rt && (id_rt == ex_rt)));
    assign stop_fetch = fetch_stop_q || (ifid_v_q && id_dec.hlt);

    // Register-file read in ID; a same-cycle WB write is visible (write-first).
    always_comb begin
        id_a = '0;
        id_b = '0;
        if ((id_rs != 5'd0) && (int'(id_rs) < NREG))
            id_a = (wb_we && (memwb_dst_q == id_rs)) ? memwb_val_q : Reg[id_rs];
        if ((id_rt != 5'd0) && (int'(id_rt) < NREG))
            id_b = (wb_we && (memwb_dst_q == id_rt)) ? memwb_val_q : Reg[id_rt];
    end

    // Operand forwarding into EX: EX/MEM (non-load) first, then MEM/WB, then ID/EX copy.
    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (exmem_v_q && exmem_we_q && !exmem_lw_q && (exmem_dst_q == ex_rs)) ex_a = exmem_res_q;
        else if (memwb_v_q && memwb_we_q && (memwb_dst_q == ex_rs))          ex_a = memwb_val_q;
        if (exmem_v_q && exmem_we_q && !exmem_lw_q && (exmem_dst_q == ex_rt)) ex_b = exmem_res_q;
        else if (memwb_v_q && memwb_we_q && (memwb_dst_q == ex_rt))          ex_b = memwb_val_q;
    end

    // ALU: R-type uses rt operand, I-type/memory use the sign-extended immediate.
    always_comb begin
        ex_res = '0;
        case (ex_op)
            OP_ADD:               ex_res = ex_a + ex_b;
            OP_SUB:               ex_res = ex_a - ex_b;
            OP_AND:               ex_res = ex_a & ex_b;
            OP_OR:                ex_res = ex_a | ex_b;
            OP_SLT:               ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_MUL:               ex_res = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + ex_imm;
            OP_SUBI:              ex_res = ex_a - ex_imm;
            OP_SLTI:              ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_imm))};
            default:              ex_res = '0;
        endcase
    end

    // Pipeline advance: branch flush beats load-use hold, which beats normal flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;  fetch_stop_q <= 1'b0;
            ifid_v_q <= 1'b0;  ifid_ir_q <= '0;  ifid_pc_q <= '0;
            idex_v_q <= 1'b0;  idex_we_q <= 1'b0;  idex_lw_q <= 1'b0;  idex_sw_q <= 1'b0;
            idex_hlt_q <= 1'b0;  idex_dst_q <= '0;  idex_ir_q <= '0;  idex_pc_q <= '0;
            idex_a_q <= '0;  idex_b_q <= '0;
            exmem_v_q <= 1'b0;  exmem_we_q <= 1'b0;  exmem_lw_q <= 1'b0;  exmem_sw_q <= 1'b0;
            exmem_hlt_q <= 1'b0;  exmem_dst_q <= '0;  exmem_res_q <= '0;  exmem_sd_q <= '0;
            memwb_v_q <= 1'b0;  memwb_we_q <= 1'b0;  memwb_hlt_q <= 1'b0;
            memwb_dst_q <= '0;  memwb_val_q <= '0;
        end else begin
            if (ex_taken) begin
                pc_q     <= ex_target;
                ifid_v_q <= 1'b0;
                idex_v_q <= 1'b0;
            end else if (load_use) begin
                idex_v_q <= 1'b0;
            end else begin
                idex_v_q   <= ifid_v_q;
                idex_we_q  <= id_dec.we;
                idex_lw_q  <= id_dec.lw;
                idex_sw_q  <= id_dec.sw;
                idex_hlt_q <= id_dec.hlt;
                idex_dst_q <= id_dec.dst;
                idex_ir_q  <= ifid_ir_q;
                idex_pc_q  <= ifid_pc_q;
                idex_a_q   <= id_a;
                idex_b_q   <= id_b;
                if (ifid_v_q && id_dec.hlt) fetch_stop_q <= 1'b1;
                if (stop_fetch) begin
                    ifid_v_q <= 1'b0;
                end else begin
                    ifid_v_q  <= 1'b1;
                    ifid_ir_q <= Mem[pc_q][31:0];
                    ifid_pc_q <= pc_q;
                    pc_q      <= pc_q + AW'(1);
                end
            end
            exmem_v_q   <= idex_v_q;
            exmem_we_q  <= idex_v_q && idex_we_q;
            exmem_lw_q  <= idex_v_q && idex_lw_q;
            exmem_sw_q  <= idex_v_q && idex_sw_q;
            exmem_hlt_q <= idex_v_q && idex_hlt_q;
            exmem_dst_q <= idex_dst_q;
            exmem_res_q <= ex_res;
            exmem_sd_q  <= ex_b;
            memwb_v_q   <= exmem_v_q;
            memwb_we_q  <= exmem_we_q;
            memwb_hlt_q <= exmem_hlt_q;
            memwb_dst_q <= exmem_dst_q;
            memwb_val_q <= exmem_lw_q ? Mem[exmem_res_q[AW-1:0]][XLEN-1:0] : exmem_res_q;
        end
    end

    // Data store in MEM; bubbles carry sw=0 so reset or halt leaves memory untouched.
    always_ff @(posedge clk) begin
        if (exmem_v_q && exmem_sw_q && !halted_q)
            Mem[exmem_res_q[AW-1:0]] <= MW'(exmem_sd_q);
    end

    // Register write-back; R0 and out-of-range targets never set we.
    always_ff @(posedge clk) begin
        if (wb_we) Reg[memwb_dst_q] <= memwb_val_q;
    end

    // Retire/halt/cycle/stall counters, all frozen once HLT has retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            instret_q <= '0;
            cycles_q  <= '0;
            stalls_q  <= '0;
        end else if (!halted_q) begin
            cycles_q <= cycles_q + 32'd1;
            if (memwb_v_q)               instret_q <= instret_q + 32'd1;
            if (memwb_v_q && memwb_hlt_q) halted_q <= 1'b1;
            if (ex_taken)                stalls_q <= stalls_q + 32'd2;
            else if (load_use)           stalls_q <= stalls_q + 32'd1;
        end
    end

    assign halted  = halted_q;
    assign instret = instret_q;
    assign cycles  = cycles_q;
    assign stalls  = stalls_q;
endmodule

// File: tb/tb_risc_pipe_core.sv
// Directed bench for risc_pipe_core: programs are preloaded into Mem, expected
// architectural results are queued, then checked after HLT retires.
module tb_risc_pipe_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted;
    logic [31:0] instret, cycles, stalls;

    risc_pipe_core #(.XLEN(32), .NREG(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .instret(instret), .cycles(cycles), .stalls(stalls)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
    localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
    localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
    localparam logic [31:0] HLT_W = {6'b111111, 26'd0};

    typedef enum int {K_REG, K_MEM, K_INSTRET, K_STALLS, K_CYCLES, K_HALTED} kind_t;
    typedef struct {
        kind_t       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        logic [4:0] d5, s5, t5;
        d5 = rd[4:0]; s5 = rs[4:0]; t5 = rt[4:0];
        return {op, s5, t5, d5, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        logic [4:0]  s5, t5;
        logic [31:0] v;
        s5 = rs[4:0]; t5 = rt[4:0]; v = imm;
        return {op, s5, t5, v[15:0]};
    endfunction

    function automatic string kname(input kind_t k);
        case (k)
            K_REG:     return "reg";
            K_MEM:     return "mem";
            K_INSTRET: return "instret";
            K_STALLS:  return "stalls";
            K_CYCLES:  return "cycles";
            default:   return "halted";
        endcase
    endfunction

    function automatic logic [31:0] observe(input kind_t k, input int idx);
        case (k)
            K_REG:     return dut.Reg[idx];
            K_MEM:     return dut.Mem[idx];
            K_INSTRET: return instret;
            K_STALLS:  return stalls;
            K_CYCLES:  return cycles;
            default:   return {31'd0, halted};
        endcase
    endfunction

    task automatic expect_val(input kind_t k, input int idx, input logic [31:0] e);
        exp_t x;
        x.kind = k; x.idx = idx; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        exp_t        x;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = observe(x.kind, x.idx);
            total++;
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s %s[%0d] observed=%0h expected=%0h", name, kname(x.kind), x.idx, obs, x.exp);
            end
        end
        $display("step %s: instret=%0d cycles=%0d stalls=%0d halted=%0b", name, instret, cycles, stalls, halted);
    endtask

    // Hold reset and clear storage so each program starts from a known image.
    task automatic begin_test();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
        for (int i = 0; i < 32; i++)   dut.Reg[i] = '0;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        rst_n = 1'b1;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (halted === 1'b1) else begin
            bad++;
            $error("FAIL halt_timeout observed=%0b expected=1", halted);
        end
    endtask

    task automatic load_factorial();
        dut.Mem[0] = enc_i(ADDI, 8, 0, 200);
        dut.Mem[1] = enc_i(ADDI, 10, 0, 1);
        dut.Mem[2] = enc_i(LW, 9, 8, 0);
        dut.Mem[3] = enc_r(MUL, 10, 10, 9);
        dut.Mem[4] = enc_i(SUBI, 9, 9, 1);
        dut.Mem[5] = enc_i(BNEQZ, 0, 9, -3);
        dut.Mem[6] = enc_i(SW, 10, 8, -2);
        dut.Mem[7] = HLT_W;
        dut.Mem[200] = 32'd7;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fact, a, b;
        fact = 1;
        for (int k = 7; k >= 1; k--) fact = fact * k;

        // Reset state
        @(negedge clk);
        expect_val(K_HALTED, 0, 0); expect_val(K_INSTRET, 0, 0);
        expect_val(K_CYCLES, 0, 0); expect_val(K_STALLS, 0, 0);
        drain("reset");

        // Addition chain with back-to-back dependencies
        begin_test();
        dut.Mem[0] = enc_i(ADDI, 1, 0, 10);
        dut.Mem[1] = enc_i(ADDI, 2, 0, 20);
        dut.Mem[2] = enc_i(ADDI, 3, 0, 25);
        dut.Mem[3] = enc_r(ADD, 4, 1, 2);
        dut.Mem[4] = enc_r(ADD, 5, 4, 3);
        dut.Mem[5] = HLT_W;
        expect_val(K_REG, 4, 30); expect_val(K_REG, 5, 55);
        expect_val(K_INSTRET, 0, 6); expect_val(K_STALLS, 0, 0);
        expect_val(K_CYCLES, 0, 10); expect_val(K_HALTED, 0, 1);
        run(200);
        drain("addition");

        // Load / add / store with one load-use stall
        begin_test();
        dut.Mem[0] = enc_i(ADDI, 6, 0, 120);
        dut.Mem[1] = enc_i(LW, 7, 6, 0);
        dut.Mem[2] = enc_i(ADDI, 7, 7, 45);
        dut.Mem[3] = enc_i(SW, 7, 6, 1);
        dut.Mem[4] = HLT_W;
        dut.Mem[120] = 32'd85;
        expect_val(K_MEM, 121, 130); expect_val(K_REG, 7, 130);
        expect_val(K_STALLS, 0, 1); expect_val(K_INSTRET, 0, 5); expect_val(K_CYCLES, 0, 10);
        run(200);
        drain("load_add_store");

        // Factorial loop: 1 load-use stall + 6 taken branches
        begin_test();
        load_factorial();
        expect_val(K_MEM, 198, fact); expect_val(K_REG, 9, 0); expect_val(K_REG, 10, fact);
        expect_val(K_STALLS, 0, 13); expect_val(K_INSTRET, 0, 26); expect_val(K_CYCLES, 0, 43);
        run(400);
        drain("factorial");

        // HLT squashes the following instruction and freezes counters
        begin_test();
        dut.Reg[1] = 32'd7;
        dut.Mem[0] = HLT_W;
        dut.Mem[1] = enc_i(ADDI, 1, 0, 99);
        expect_val(K_REG, 1, 7); expect_val(K_HALTED, 0, 1);
        expect_val(K_CYCLES, 0, 5); expect_val(K_INSTRET, 0, 1); expect_val(K_STALLS, 0, 0);
        run(100);
        repeat (20) @(negedge clk);
        drain("hlt_squash");

        // Asynchronous reset in the middle of the factorial loop, then re-run
        begin_test();
        load_factorial();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_val(K_HALTED, 0, 0); expect_val(K_INSTRET, 0, 0);
        expect_val(K_CYCLES, 0, 0); expect_val(K_STALLS, 0, 0);
        drain("reset_midrun");
        repeat (3) @(negedge clk);
        expect_val(K_MEM, 198, 0);
        drain("reset_hold");
        expect_val(K_MEM, 198, fact); expect_val(K_REG, 9, 0);
        expect_val(K_STALLS, 0, 13); expect_val(K_INSTRET, 0, 26);
        run(400);
        drain("reset_rerun");

        // R0 stays zero; addresses wrap modulo MEM_DEPTH
        begin_test();
        dut.Mem[1023] = 32'hDEAD;
        dut.Mem[0] = enc_i(ADDI, 0, 0, 5);
        dut.Mem[1] = enc_i(SW, 0, 0, 1023);
        dut.Mem[2] = enc_i(ADDI, 1, 0, 1030);
        dut.Mem[3] = enc_i(SW, 1, 1, 0);
        dut.Mem[4] = HLT_W;
        expect_val(K_REG, 0, 0); expect_val(K_MEM, 1023, 0);
        expect_val(K_REG, 1, 1030); expect_val(K_MEM, 6, 1030);
        run(200);
        drain("r0_wrap");

        // Remaining ALU operations with negative operands
        begin_test();
        a = -5; b = 3;
        dut.Mem[0]  = enc_i(ADDI, 1, 0, a);
        dut.Mem[1]  = enc_i(ADDI, 2, 0, b);
        dut.Mem[2]  = enc_r(SLT, 3, 1, 2);
        dut.Mem[3]  = enc_r(SLT, 4, 2, 1);
        dut.Mem[4]  = enc_r(SUB, 5, 2, 1);
        dut.Mem[5]  = enc_r(AND_, 6, 1, 2);
        dut.Mem[6]  = enc_r(OR_, 7, 1, 2);
        dut.Mem[7]  = enc_i(SLTI, 8, 1, -4);
        dut.Mem[8]  = enc_i(SUBI, 9, 2, 10);
        dut.Mem[9]  = enc_r(MUL, 11, 1, 2);
        dut.Mem[10] = HLT_W;
        expect_val(K_REG, 3, (a < b) ? 1 : 0); expect_val(K_REG, 4, (b < a) ? 1 : 0);
        expect_val(K_REG, 5, b - a); expect_val(K_REG, 6, a & b); expect_val(K_REG, 7, a | b);
        expect_val(K_REG, 8, (a < -4) ? 1 : 0); expect_val(K_REG, 9, b - 10);
        expect_val(K_REG, 11, a * b); expect_val(K_INSTRET, 0, 11);
        run(200);
        drain("alu");

        // BEQZ not-taken / taken, and a taken branch flushing an HLT in ID
        begin_test();
        dut.Reg[2] = 32'd55;
        dut.Mem[0] = enc_i(ADDI, 1, 0, 3);
        dut.Mem[1] = enc_i(BEQZ, 0, 1, 1);
        dut.Mem[2] = enc_i(BEQZ, 0, 0, 1);
        dut.Mem[3] = enc_i(ADDI, 2, 0, 9);
        dut.Mem[4] = enc_i(ADDI, 3, 0, 4);
        dut.Mem[5] = enc_i(BNEQZ, 0, 1, 1);
        dut.Mem[6] = HLT_W;
        dut.Mem[7] = enc_i(ADDI, 4, 0, 8);
        dut.Mem[8] = HLT_W;
        expect_val(K_REG, 2, 55); expect_val(K_REG, 3, 4); expect_val(K_REG, 4, 8);
        expect_val(K_STALLS, 0, 4); expect_val(K_INSTRET, 0, 7); expect_val(K_CYCLES, 0, 15);
        run(200);
        drain("branches");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
